dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer and owner arbiter for the DDS phase-accumulator tuning word (m, set, en).
- Idle: the UART command path (manual m/set/en) passes through to the DDS core.
- After a go pulse: the block takes ownership and steps m from a start word to a stop word in fixed increments.
- Each new word is issued with a one-cycle set pulse and then held for a programmable dwell.
- Sits between the UART command decoder and the DDS core.

Parameters:
W, 40, tuning-word width (matches m)
DWELL_W, 24, dwell counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
man_m  in  W  manual tuning word from command decoder
man_set  in  1  manual latch pulse
man_en  in  1  manual DDS enable level
start_word  in  W  sweep first word
stop_word  in  W  sweep upper bound (inclusive)
step_word  in  W  increment per point
dwell  in  DWELL_W  clocks to hold each word; 0 treated as 1
repeat  in  1  1 = restart from start_word after last point, 0 = one-shot
go  in  1  start pulse (honoured only in IDLE)
abort  in  1  stop pulse
m  out  W  tuning word to DDS core
set  out  1  DDS latch pulse
en  out  1  DDS enable
busy  out  1  high while sweep owns DDS
done  out  1  one-cycle pulse, one-shot sweep completed
aborted  out  1  one-cycle pulse, sweep terminated by abort
cfg_err  out  1  one-cycle pulse, go rejected
man_blocked  out  1  one-cycle pulse, man_set arrived while busy (dropped)

Behaviour:
- Reset values: m=0, set=0, en=0, busy=0, done=0, aborted=0, cfg_err=0, man_blocked=0; state=IDLE; internal accumulator and counter =0.
- All outputs are registered.
- IDLE:
  - m<=man_m, set<=man_set, en<=man_en (1-cycle latency).
  - On go: validity check is step_word!=0 and start_word<=stop_word (unsigned).
  - Valid go: snapshot start/stop/step/dwell/repeat into shadow registers → LOAD.
  - Invalid go: cfg_err pulse, stay IDLE.
- Input changes after go are ignored until the next go.
- LOAD (1 cycle): acc<=start; m<=start; set<=1; en<=1; busy<=1; cnt<=1 → DWELL.
- DWELL:
  - set<=0.
  - If cnt==max(dwell,1) → STEP; else cnt<=cnt+1.
- STEP (1 cycle):
  - nxt=acc+step computed in W+1 bits.
  - If nxt carry or nxt>stop: repeat=1 → LOAD; repeat=0 → DONE.
  - Else acc<=nxt; m<=nxt; set<=1; cnt<=1 → DWELL.
- DONE (1 cycle): done<=1; busy<=0 → IDLE. m holds the last sweep word until IDLE pass-through resumes next cycle.
- Timing:
  - set pulses are spaced exactly max(dwell,1)+1 clocks apart.
  - A LOAD re-entered on repeat issues start_word at the same spacing.
  - done is asserted max(dwell,1)+2 clocks after the last set pulse.
- Abort:
  - Non-IDLE state: next cycle → IDLE; set<=0; busy<=0; aborted<=1; done not asserted.
  - Abort has priority over a same-cycle STEP set.
  - Abort in IDLE is ignored; abort+go in the same IDLE cycle: abort wins, go discarded, no cfg_err.
- Busy (all states except IDLE):
  - en forced 1; man_m and man_en ignored.
  - man_set: man_blocked pulse, set not propagated.
- Point count: floor((stop-start)/step)+1. start==stop yields exactly one point.
- Wrap-around: stop near 2^W-1 with the add carrying terminates; the tuning word never wraps.
- Reset mid-sweep: immediate return to reset values; no done/aborted pulse.

Decomposition:
- Shared header dds_defs.vh: W default, state encodings (IDLE, LOAD, DWELL, STEP, DONE), DWELL_W default. Shared with the command decoder for a future sweep-config command set.
- One natural sub-module: dds_dwell_timer (load, count, expire flag; handles dwell=0 → 1).

Test Plan:
1. start=100, stop=130, step=10, dwell=3, repeat=0, go → set pulses with m=100,110,120,130 every 4 clocks; done 5 clocks after m=130; busy low after done.
2. repeat=1, start=0, stop=20, step=10, dwell=1; abort after 7 set pulses → m sequence 0,10,20,0,10,20,0; aborted pulse; no done; IDLE pass-through resumes.
3. go with step=0, or with start=50, stop=40 → cfg_err single pulse, busy stays 0, m tracks man_m.
4. start=2^40-3, stop=2^40-1, step=2, dwell=0 → points 2^40-3, 2^40-1 spaced 2 clocks, then done; no wrap to small values.
5. man_set pulse with man_m=0x1234 during sweep → man_blocked pulse, m unchanged. Same stimulus in IDLE → m=0x1234 and set pulse one clock later.
6. rst asserted during DWELL → next cycle all outputs at reset values; subsequent go starts a clean sweep from start_word.

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller and its command-path peers.
// Holds default widths and the sweep state encoding.
package dds_sweep_ctrl_pkg;

    localparam int W_DEF       = 40;
    localparam int DWELL_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DWELL = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: loads to 1, counts up, flags when the programmed dwell is reached.
// A programmed dwell of 0 behaves as a dwell of 1.
module dds_sweep_ctrl_dwell_timer
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_count,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_limit;

    assign w_limit  = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign o_expire = (r_cnt == w_limit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= DWELL_W'(1);
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer and owner arbiter for the DDS tuning word.
// Idle passes the manual command path through; a sweep owns the DDS until done/abort.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [W-1:0]       i_man_m,
    input  logic               i_man_set,
    input  logic               i_man_en,
    input  logic [W-1:0]       i_start_word,
    input  logic [W-1:0]       i_stop_word,
    input  logic [W-1:0]       i_step_word,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_repeat,
    input  logic               i_go,
    input  logic               i_abort,
    output logic [W-1:0]       o_m,
    output logic               o_set,
    output logic               o_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic               o_cfg_err,
    output logic               o_man_blocked
);

    state_t             r_state;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_start;
    logic [W-1:0]       r_stop;
    logic [W-1:0]       r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_rep;
    logic [W-1:0]       r_m;
    logic               r_set;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               r_cfg_err;
    logic               r_man_blocked;

    state_t             w_state_nxt;
    logic [W-1:0]       w_acc_nxt;
    logic [W-1:0]       w_m_nxt;
    logic               w_set_nxt;
    logic               w_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_aborted_nxt;
    logic               w_cfg_err_nxt;
    logic               w_blk_nxt;
    logic               w_snap;
    logic               w_tmr_load;
    logic               w_tmr_count;
    logic               w_expire;
    logic               w_cfg_ok;
    logic [W:0]         w_sum;
    logic               w_over;

    assign w_cfg_ok = (i_step_word != '0) && (i_start_word <= i_stop_word);
    // Extra carry bit keeps the tuning word from ever wrapping past stop.
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_step};
    assign w_over   = w_sum[W] || (w_sum[W-1:0] > r_stop);

    dds_sweep_ctrl_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_tmr_load),
        .i_count  (w_tmr_count),
        .i_dwell  (r_dwell),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_m_nxt       = r_m;
        w_set_nxt     = 1'b0;
        w_en_nxt      = r_en;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_blk_nxt     = 1'b0;
        w_snap        = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_count   = 1'b0;

        if (r_state == ST_IDLE) begin
            w_m_nxt    = i_man_m;
            w_set_nxt  = i_man_set;
            w_en_nxt   = i_man_en;
            w_busy_nxt = 1'b0;
            if (i_go && !i_abort) begin
                if (w_cfg_ok) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cfg_err_nxt = 1'b1;
                end
            end
        end else begin
            w_en_nxt  = 1'b1;
            w_blk_nxt = i_man_set;
            if (i_abort) begin
                w_state_nxt   = ST_IDLE;
                w_busy_nxt    = 1'b0;
                w_aborted_nxt = 1'b1;
            end else begin
                unique case (r_state)
                    ST_LOAD: begin
                        w_acc_nxt   = r_start;
                        w_m_nxt     = r_start;
                        w_set_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_DWELL;
                    end
                    ST_DWELL: begin
                        w_tmr_count = 1'b1;
                        if (w_expire) begin
                            w_state_nxt = ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        if (!w_over) begin
                            w_acc_nxt   = w_sum[W-1:0];
                            w_m_nxt     = w_sum[W-1:0];
                            w_set_nxt   = 1'b1;
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ST_DWELL;
                        end else if (r_rep) begin
                            // Reload in place so the restart keeps the point spacing.
                            w_acc_nxt   = r_start;
                            w_m_nxt     = r_start;
                            w_set_nxt   = 1'b1;
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ST_DWELL;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_start       <= '0;
            r_stop        <= '0;
            r_step        <= '0;
            r_dwell       <= '0;
            r_rep         <= 1'b0;
            r_m           <= '0;
            r_set         <= 1'b0;
            r_en          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_man_blocked <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_m           <= w_m_nxt;
            r_set         <= w_set_nxt;
            r_en          <= w_en_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_aborted     <= w_aborted_nxt;
            r_cfg_err     <= w_cfg_err_nxt;
            r_man_blocked <= w_blk_nxt;
            if (w_snap) begin
                r_start <= i_start_word;
                r_stop  <= i_stop_word;
                r_step  <= i_step_word;
                r_dwell <= i_dwell;
                r_rep   <= i_repeat;
            end
        end
    end

    assign o_m           = r_m;
    assign o_set         = r_set;
    assign o_en          = r_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_cfg_err     = r_cfg_err;
    assign o_man_blocked = r_man_blocked;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: idle vector table plus scoreboarded sweep sequences.
// Expected sweep points come from a small reference model of the stepping rule.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic [39:0] man_m;
    logic        man_set;
    logic        man_en;
    logic [39:0] start_w;
    logic [39:0] stop_w;
    logic [39:0] step_w;
    logic [23:0] dwell;
    logic        rep;
    logic        go;
    logic        abort;
    logic [39:0] o_m;
    logic        o_set;
    logic        o_en;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic        o_cfg_err;
    logic        o_man_blocked;

    dds_sweep_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_man_m       (man_m),
        .i_man_set     (man_set),
        .i_man_en      (man_en),
        .i_start_word  (start_w),
        .i_stop_word   (stop_w),
        .i_step_word   (step_w),
        .i_dwell       (dwell),
        .i_repeat      (rep),
        .i_go          (go),
        .i_abort       (abort),
        .o_m           (o_m),
        .o_set         (o_set),
        .o_en          (o_en),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_aborted     (o_aborted),
        .o_cfg_err     (o_cfg_err),
        .o_man_blocked (o_man_blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] m;
        int          gap;
    } exp_t;

    typedef struct {
        logic [39:0] mm;
        logic        ms;
        logic        me;
        logic [39:0] st;
        logic [39:0] sp;
        logic [39:0] stp;
        logic        go;
        logic        ab;
        logic [39:0] em;
        logic        es;
        logic        ee;
        logic        ecfg;
        logic        ebusy;
        logic        eab;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[8];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_set = 0;
    int   n_set = 0;
    int   n_done = 0;
    int   n_abort = 0;
    bit   mon_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_on && o_set) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL set_unexpected actual=%0h expected=none", o_m);
            end else begin
                e = sbq.pop_front();
                chk("set_m", o_m, e.m);
                if (e.gap != 0) chk("set_gap", cyc - last_set, e.gap);
            end
            last_set = cyc;
            n_set++;
        end
        if (o_done) n_done++;
        if (o_aborted) n_abort++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_sweep(input logic [39:0] s, input logic [39:0] e,
                              input logic [39:0] st, input int dw);
        logic [40:0] a;
        logic [40:0] n;
        int          g;
        int          de;
        de = (dw == 0) ? 1 : dw;
        a  = {1'b0, s};
        g  = 0;
        for (int k = 0; k < 64; k++) begin
            sbq.push_back('{a[39:0], g});
            n = a + {1'b0, st};
            if (n[40] || n[39:0] > e) break;
            a = n;
            g = de + 1;
        end
    endtask

    task automatic start_sweep(input logic [39:0] s, input logic [39:0] e,
                               input logic [39:0] st, input int dw,
                               input logic r);
        start_w = s;
        stop_w  = e;
        step_w  = st;
        dwell   = 24'(dw);
        rep     = r;
        go      = 1'b1;
        tick();
        go      = 1'b0;
        start_w = 40'h0;
        stop_w  = 40'h0;
        step_w  = 40'h0;
        dwell   = 24'h0;
        rep     = 1'b0;
    endtask

    task automatic wait_sets(input int target, input int max);
        for (int i = 0; i < max && n_set < target; i++) tick();
        if (n_set < target) chk("set_timeout", 64'(n_set), 64'(target));
    endtask

    task automatic wait_done(input int max, input logic [39:0] lastm,
                             input int delta);
        bit got;
        int ab0;
        got = 0;
        ab0 = n_abort;
        for (int i = 0; i < max; i++) begin
            tick();
            if (o_done) begin
                got = 1;
                chk("done_delay", cyc - last_set, delta);
                chk("done_m", o_m, lastm);
                chk("done_busy", o_busy, 0);
                break;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("done_no_abort", n_abort - ab0, 0);
        chk("sb_empty", sbq.size(), 0);
        tick();
        chk("done_one_cycle", o_done, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m"}, o_m, 0);
        chk({tag, "_set"}, o_set, 0);
        chk({tag, "_en"}, o_en, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_aborted"}, o_aborted, 0);
        chk({tag, "_cfg_err"}, o_cfg_err, 0);
        chk({tag, "_blocked"}, o_man_blocked, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; man_m = 40'h0; man_set = 1'b0; man_en = 1'b0;
        start_w = 40'h0; stop_w = 40'h0; step_w = 40'h0; dwell = 24'h0;
        rep = 1'b0; go = 1'b0; abort = 1'b0;

        vt[0] = '{40'h1234, 1, 1, 40'd0,  40'd10, 40'd1, 0, 0, 40'h1234, 1, 1, 0, 0, 0};
        vt[1] = '{40'h55,   0, 0, 40'd0,  40'd10, 40'd1, 0, 0, 40'h55,   0, 0, 0, 0, 0};
        vt[2] = '{40'h77,   0, 1, 40'd0,  40'd10, 40'd0, 1, 0, 40'h77,   0, 1, 1, 0, 0};
        vt[3] = '{40'h88,   0, 1, 40'd50, 40'd40, 40'd1, 1, 0, 40'h88,   0, 1, 1, 0, 0};
        vt[4] = '{40'h99,   0, 1, 40'd50, 40'd40, 40'd1, 0, 0, 40'h99,   0, 1, 0, 0, 0};
        vt[5] = '{40'hAA,   0, 1, 40'd0,  40'd10, 40'd1, 1, 1, 40'hAA,   0, 1, 0, 0, 0};
        vt[6] = '{40'hBB,   1, 1, 40'd0,  40'd10, 40'd1, 0, 1, 40'hBB,   1, 1, 0, 0, 0};
        vt[7] = '{40'hCC,   0, 0, 40'd0,  40'd10, 40'd1, 0, 0, 40'hCC,   0, 0, 0, 0, 0};

        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            man_m = vt[i].mm; man_set = vt[i].ms; man_en = vt[i].me;
            start_w = vt[i].st; stop_w = vt[i].sp; step_w = vt[i].stp;
            go = vt[i].go; abort = vt[i].ab;
            tick();
            chk($sformatf("v%0d_m", i), o_m, vt[i].em);
            chk($sformatf("v%0d_set", i), o_set, vt[i].es);
            chk($sformatf("v%0d_en", i), o_en, vt[i].ee);
            chk($sformatf("v%0d_cfg_err", i), o_cfg_err, vt[i].ecfg);
            chk($sformatf("v%0d_busy", i), o_busy, vt[i].ebusy);
            chk($sformatf("v%0d_aborted", i), o_aborted, vt[i].eab);
        end
        go = 1'b0; abort = 1'b0; man_set = 1'b0; man_en = 1'b0; man_m = 40'h0;
        tick();
        mon_on = 1;

        push_sweep(40'd100, 40'd130, 40'd10, 3);
        start_sweep(40'd100, 40'd130, 40'd10, 3, 1'b0);
        wait_sets(n_set + 1, 20);
        chk("t1_busy", o_busy, 1);
        chk("t1_en", o_en, 1);
        wait_done(60, 40'd130, 5);
        chk("t1_busy_after", o_busy, 0);

        d0 = n_done;
        man_m = 40'hABC;
        sbq.push_back('{40'd0, 0});
        for (int r = 0; r < 2; r++) begin
            sbq.push_back('{40'd10, 2});
            sbq.push_back('{40'd20, 2});
            sbq.push_back('{40'd0, 2});
        end
        start_sweep(40'd0, 40'd20, 40'd10, 1, 1'b1);
        wait_sets(n_set + 7, 60);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t2_aborted", o_aborted, 1);
        chk("t2_busy", o_busy, 0);
        chk("t2_set", o_set, 0);
        tick();
        chk("t2_aborted_pulse", o_aborted, 0);
        chk("t2_passthru_m", o_m, 40'hABC);
        chk("t2_no_done", n_done - d0, 0);
        chk("t2_sb_empty", sbq.size(), 0);
        man_m = 40'h0;
        tick();

        push_sweep(40'hFF_FFFF_FFFD, 40'hFF_FFFF_FFFF, 40'd2, 0);
        start_sweep(40'hFF_FFFF_FFFD, 40'hFF_FFFF_FFFF, 40'd2, 0, 1'b0);
        wait_done(30, 40'hFF_FFFF_FFFF, 3);

        push_sweep(40'd5, 40'd5, 40'd1, 20);
        start_sweep(40'd5, 40'd5, 40'd1, 20, 1'b0);
        wait_sets(n_set + 1, 20);
        man_m = 40'h1234;
        man_set = 1'b1;
        tick();
        man_set = 1'b0;
        chk("t5_blocked", o_man_blocked, 1);
        chk("t5_m_held", o_m, 40'd5);
        chk("t5_set_dropped", o_set, 0);
        wait_done(60, 40'd5, 22);
        mon_on = 0;
        man_set = 1'b1;
        tick();
        man_set = 1'b0;
        chk("t5_idle_m", o_m, 40'h1234);
        chk("t5_idle_set", o_set, 1);
        chk("t5_idle_blocked", o_man_blocked, 0);
        tick();
        chk("t5_idle_set_end", o_set, 0);
        man_m = 40'h0;
        tick();
        mon_on = 1;

        push_sweep(40'd1000, 40'd2000, 40'd100, 10);
        start_sweep(40'd1000, 40'd2000, 40'd100, 10, 1'b0);
        wait_sets(n_set + 1, 20);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        sbq.delete();
        tick();
        chk("midrst_idle_busy", o_busy, 0);
        push_sweep(40'd7, 40'd9, 40'd1, 2);
        start_sweep(40'd7, 40'd9, 40'd1, 2, 1'b0);
        wait_done(60, 40'd9, 4);
        mon_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
